// File: rtl/alu_pkg.sv
// Shared types and constants for the alu issue/retire slice.
// Optional accumulator feature is selected with ALU_ACC_EN.
package alu_pkg;

   localparam int ALU_WIDTH = 4;
   localparam int ALU_CMD_W = 3;

   localparam logic [2:0] CMD_NOP = 3'b000;
   localparam logic [2:0] CMD_ADD = 3'b001;
   localparam logic [2:0] CMD_SUB = 3'b010;
   localparam logic [2:0] CMD_AND = 3'b011;
   localparam logic [2:0] CMD_OR  = 3'b100;
   localparam logic [2:0] CMD_XOR = 3'b101;
   localparam logic [2:0] CMD_SHL = 3'b110;
   localparam logic [2:0] CMD_SHR = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      STALL
   } x_state_e;

endpackage

// File: rtl/alu_issue_if.sv
// Issue-side and result-side handshake bundle for alu_issue_ctrl.
// in_acc exists only when ALU_ACC_EN is defined.
interface alu_issue_if #(
   parameter int WIDTH = 4,
   parameter int CMD_W = 3,
   parameter int DEPTH = 2
);

   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         in_a;
   logic [WIDTH-1:0]         in_b;
   logic [CMD_W-1:0]         in_cmd;
`ifdef ALU_ACC_EN
   logic                     in_acc;
`endif
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         out_res;
   logic [CMD_W-1:0]         out_cmd;
   logic [$clog2(DEPTH):0]   out_count;

   modport master (
`ifdef ALU_ACC_EN
      output in_acc,
`endif
      output in_valid, in_a, in_b, in_cmd, out_ready,
      input  in_ready, out_valid, out_res, out_cmd, out_count
   );

   modport slave (
`ifdef ALU_ACC_EN
      input  in_acc,
`endif
      input  in_valid, in_a, in_b, in_cmd, out_ready,
      output in_ready, out_valid, out_res, out_cmd, out_count
   );

endinterface

// File: rtl/alu.sv
// Combinational ALU: add/sub/logic ops and shifts by b[1:0].
// NOP yields zero; the result wraps at WIDTH bits.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CMD_W = ALU_CMD_W
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [CMD_W-1:0] cmd,
   output logic [WIDTH-1:0] res
);

   always_comb begin
      res = '0;
      unique case (cmd)
         CMD_ADD: res = a + b;
         CMD_SUB: res = a - b;
         CMD_AND: res = a & b;
         CMD_OR:  res = a | b;
         CMD_XOR: res = a ^ b;
         CMD_SHL: res = a << b[1:0];
         CMD_SHR: res = a >> b[1:0];
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/alu_result_fifo.sv
// Circular result FIFO; push and pop together when full keeps occupancy.
// Storage resets to zero so the head reads zero out of reset.
module alu_result_fifo #(
   parameter int WIDTH = 4,
   parameter int CMD_W = 3,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         push_res,
   input  logic [CMD_W-1:0]         push_cmd,
   output logic [WIDTH-1:0]         head_res,
   output logic [CMD_W-1:0]         head_cmd,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] res_q [DEPTH];
   logic [CMD_W-1:0] cmd_q [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt_q;

   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign head_res = res_q[rd_ptr];
   assign head_cmd = cmd_q[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            res_q[i] <= '0;
            cmd_q[i] <= '0;
         end
      end else begin
         if (push) begin
            res_q[wr_ptr] <= push_res;
            cmd_q[wr_ptr] <= push_cmd;
            wr_ptr        <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/retire stage around alu with a result FIFO.
// Define ALU_ACC_EN to add the in_acc operand-a accumulator.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CMD_W = ALU_CMD_W,
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   alu_issue_if.slave bus
);

   x_state_e         state_q;
   x_state_e         state_d;
   logic             x_valid;
   logic [WIDTH-1:0] x_a;
   logic [WIDTH-1:0] x_b;
   logic [CMD_W-1:0] x_cmd;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] alu_res;
   logic             x_nop;
   logic             x_retire;
   logic             accept;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;

   assign x_valid  = (state_q != IDLE);
   assign x_nop    = (x_cmd == CMD_W'(CMD_NOP));
   assign pop      = bus.out_valid && bus.out_ready;
   assign x_retire = x_valid && (x_nop || !fifo_full || pop);
   assign push     = x_retire && !x_nop;
   assign accept   = bus.in_valid && bus.in_ready;

   assign bus.in_ready  = !x_valid || x_retire;
   assign bus.out_valid = !fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = EXEC;
         end
         EXEC, STALL: begin
            if (accept)         state_d = EXEC;
            else if (!x_retire) state_d = STALL;
            else                state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_a   <= '0;
         x_b   <= '0;
         x_cmd <= '0;
      end else if (accept) begin
         x_a   <= bus.in_a;
         x_b   <= bus.in_b;
         x_cmd <= bus.in_cmd;
      end
   end

`ifdef ALU_ACC_EN
   logic             x_acc;
   logic [WIDTH-1:0] acc_q;

   // Retire is in order, so acc_q is always the last non-NOP result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_acc <= 1'b0;
         acc_q <= '0;
      end else begin
         if (accept) x_acc <= bus.in_acc;
         if (push)   acc_q <= alu_res;
      end
   end

   assign op_a = x_acc ? acc_q : x_a;
`else
   assign op_a = x_a;
`endif

   alu #(
      .WIDTH (WIDTH),
      .CMD_W (CMD_W)
   ) u_alu (
      .a   (op_a),
      .b   (x_b),
      .cmd (x_cmd),
      .res (alu_res)
   );

   alu_result_fifo #(
      .WIDTH (WIDTH),
      .CMD_W (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .push_res (alu_res),
      .push_cmd (x_cmd),
      .head_res (bus.out_res),
      .head_cmd (bus.out_cmd),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (bus.out_count)
   );

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue and retire stage wrapped around the combinational `alu`. Accepts operand/command tuples over a valid/ready handshake and registers them into an execute stage. Drives the `alu` instance, then buffers results in a 2-entry output FIFO for the downstream consumer. Decouples producers from consumers, gives single-cycle throughput, and supports backpressure.

## Interface
Parameters:
- `WIDTH`, 4, operand/result width; must match `alu`.
- `CMD_W`, 3, command width.
- `DEPTH`, 2, output FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: upstream tuple valid.
- `in_ready` out 1: block can accept a tuple this cycle.
- `in_a` in WIDTH: operand a.
- `in_b` in WIDTH: operand b.
- `in_cmd` in CMD_W: `alu` command; `3'b000` = NOP.
- `in_acc` in 1: use accumulator as operand a; only present with `ALU_ACC_EN`.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream consumes head.
- `out_res` out WIDTH: head result.
- `out_cmd` out CMD_W: command that produced head result.
- `out_count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Execute register (X) holds `x_valid`, `x_a`, `x_b`, `x_cmd`, `x_acc`.
- FSM on X: `IDLE` (X empty), `EXEC` (X full, result retiring this cycle), `STALL` (X full, FIFO full, non-NOP).
- `IDLE` → `EXEC` on accept.
- `EXEC` stays `EXEC` on accept, otherwise → `IDLE`.
- `EXEC` → `STALL` when the FIFO becomes full while X holds a non-NOP.
- `STALL` → `EXEC` when a FIFO slot frees.
- Accept = `in_valid && in_ready`.
- `in_ready = !x_valid || x_retire`.
- `x_retire = x_valid && (x_cmd == 0 || !fifo_full || (out_valid && out_ready))`.
- Retire of a non-NOP writes {`alu` result, `x_cmd`} into the FIFO.
- Retire of a NOP writes nothing; a NOP never stalls.
- FIFO: circular, pointers wrap modulo `DEPTH`.
- Simultaneous push and pop when full is permitted; occupancy is unchanged.
- Results retire strictly in issue order.
- Result width is `WIDTH`; the `alu` output is taken as-is, no extension or saturation.
- Reset mid-operation discards X and all FIFO contents immediately.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_res`=0, `out_cmd`=0, `out_count`=0.
  - FSM=`IDLE`, accumulator=0.
- Latency: tuple accepted at edge N → `out_valid`=1 with its result after edge N+1 (if the FIFO was empty).
- Throughput: one tuple per cycle while `out_ready`=1.
- `out_res`/`out_cmd` stable while `out_valid && !out_ready`.
- `in_ready` is combinational from X/FIFO state and `out_ready`; it has no path from `in_valid`.
- Maximum in flight: `DEPTH`+1 (FIFO full plus X held).

## Configuration
- `ALU_ACC_EN` defined:
  - `in_acc` port exists; 1 accumulator register of WIDTH.
  - On each non-NOP retire, the accumulator is loaded with the result.
  - When `x_acc`=1, the `alu` operand a is the accumulator instead of `x_a`.
  - Because retire is in order, the accumulator always equals the previous non-NOP result, including back-to-back ops.
- `ALU_ACC_EN` undefined: no `in_acc` port, no accumulator; operand a is always `x_a`.

## Structure
- Shared package `alu_pkg`: `WIDTH`/`CMD_W` defaults, `CMD_NOP`=3'b000, FSM state enum (`IDLE`, `EXEC`, `STALL`).
- One natural sub-module: `alu_result_fifo` (parameterized `DEPTH`, push/pop, full/empty/count).
- `alu` is instantiated unchanged.

## Test plan
- Reset: assert `rst` mid-cycle with the FIFO holding 2 entries → `out_valid`=0, `out_count`=0, `in_ready`=1 asynchronously; nothing reappears after release.
- Single op: a=10, b=1, cmd=3'b001, `out_ready`=1 → one cycle after accept, `out_valid`=1, `out_res` = `alu`(10,1,001), `out_cmd`=001.
- Back-to-back: 8 ops, cmd 001..111 then 001, `out_ready`=1 → 8 results in order, one per cycle, `in_ready` never low.
- Backpressure: `out_ready`=0, drive 4 ops → 3 accepted, `in_ready`=0 on the 4th, `out_count`=2; raise `out_ready` → 4th accepted next cycle, no loss or reorder.
- NOP: cmd=000 interleaved between 2 ops → exactly 2 results, `out_count` never counts the NOP; NOP accepted even when the FIFO is full.
- `ALU_ACC_EN`: op1 a=15, b=12, cmd=101; op2 `in_acc`=1, b=3, cmd=001, back-to-back → op2 result = `alu`(res1,3,001); after reset, an `in_acc` op uses operand a=0.
